// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared mode encodings and width helper for the edge detector bank

package edge_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// rtl/edge_chan.sv - one channel: synchroniser, debounce filter, edge pulse and sticky pending flag

module edge_chan
    import edge_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 4,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       pulse,
    output logic       pending
);

    localparam int            CW       = clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   pending_q, pending_d;
    logic                   synced;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];

    // Direction qualifier evaluated against the value about to become the new level.
    always_comb begin
        accept = 1'b0;
        case (mode)
            MODE_OFF:  accept = 1'b0;
            MODE_RISE: accept = synced;
            MODE_FALL: accept = ~synced;
            MODE_BOTH: accept = 1'b1;
            default:   accept = 1'b0;
        endcase
    end

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = synced;
            cnt_d   = '0;
            pulse_d = accept;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        // A new edge beats a simultaneous clear so no event is lost.
        if (pulse_d) begin
            pending_d = 1'b1;
        end else if (clr) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            level_q   <= INIT_LEVEL;
            pulse_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
        end
    end

    assign level   = level_q;
    assign pulse   = pulse_q;
    assign pending = pending_q;

endmodule

// File: rtl/edge_detect_bank.sv
// rtl/edge_detect_bank.sv - bank of independent edge channels with a registered masked interrupt

module edge_detect_bank
    import edge_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              DEBOUNCE    = 4,
    parameter logic [N_CH-1:0] INIT_LEVEL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   din,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   irq_en,
    input  logic [N_CH-1:0]   clr,
    output logic [N_CH-1:0]   level,
    output logic [N_CH-1:0]   pulse,
    output logic [N_CH-1:0]   pending,
    output logic              irq
);

    logic irq_q, irq_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .INIT_LEVEL  (INIT_LEVEL[i])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .din     (din[i]),
            .mode    (mode[2*i+1:2*i]),
            .clr     (clr[i]),
            .level   (level[i]),
            .pulse   (pulse[i]),
            .pending (pending[i])
        );
    end

    // Built from registered pending, so irq trails pending by one cycle.
    always_comb begin
        irq_d = |(pending & irq_en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_edge_detect_bank.sv
// tb/tb_edge_detect_bank.sv - scoreboard bench for edge_detect_bank

module tb_edge_detect_bank;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] irq_en;
    logic [3:0] clr;
    logic [3:0] level;
    logic [3:0] pulse;
    logic [3:0] pending;
    logic       irq;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int         at;
        logic [3:0] vec;
    } exp_t;

    exp_t exp_q[$];

    edge_detect_bank #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .DEBOUNCE    (4),
        .INIT_LEVEL  (4'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .mode    (mode),
        .irq_en  (irq_en),
        .clr     (clr),
        .level   (level),
        .pulse   (pulse),
        .pending (pending),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [3:0] vec);
        exp_t e;
        e.at  = at;
        e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every observed pulse must match the oldest expected pulse in cycle and channel set.
    always @(negedge clk) begin
        if (rst && pulse != 4'h0) begin
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_pulse: got %0h expected none (cycle %0d)", pulse, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_vec", {28'd0, pulse}, {28'd0, e.vec});
            end
        end
    end

    initial begin
        int c;
        rst    = 1'b0;
        din    = 4'hF;
        mode   = 8'h00;
        irq_en = 4'h0;
        clr    = 4'h0;

        // 1. reset with all inputs high
        step(2);
        chk("rst_level_mid", {28'd0, level}, 32'h0);
        step(3);
        chk("rst_level", {28'd0, level}, 32'h0);
        chk("rst_pulse", {28'd0, pulse}, 32'h0);
        chk("rst_pending", {28'd0, pending}, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        din = 4'h0;
        rst = 1'b1;
        step(8);

        // 2. ch0 rising edge latency, pending and irq lag
        mode   = 8'b00_00_00_01;
        irq_en = 4'b0001;
        c = cyc;
        din[0] = 1'b1;
        expect_pulse(c + 6, 4'b0001);
        step(5);
        chk("t2_level_before", {31'd0, level[0]}, 32'h0);
        chk("t2_pending_before", {31'd0, pending[0]}, 32'h0);
        step(1);
        chk("t2_level", {31'd0, level[0]}, 32'h1);
        chk("t2_pending", {31'd0, pending[0]}, 32'h1);
        chk("t2_irq_lag", {31'd0, irq}, 32'h0);
        step(1);
        chk("t2_irq", {31'd0, irq}, 32'h1);
        clr[0] = 1'b1;
        step(1);
        clr[0] = 1'b0;
        chk("t2_clr_pending", {31'd0, pending[0]}, 32'h0);
        chk("t2_irq_hold", {31'd0, irq}, 32'h1);
        step(1);
        chk("t2_irq_drop", {31'd0, irq}, 32'h0);
        irq_en = 4'h0;

        // 3. ch1 glitch of 3 cycles is filtered
        mode[3:2] = 2'b11;
        din[1] = 1'b1;
        step(3);
        din[1] = 1'b0;
        step(10);
        chk("t3_level", {31'd0, level[1]}, 32'h0);
        chk("t3_pending", {31'd0, pending[1]}, 32'h0);

        // 4. ch2 both edges, clear coincident with second pulse loses to set
        mode[5:4] = 2'b11;
        c = cyc;
        din[2] = 1'b1;
        expect_pulse(c + 6, 4'b0100);
        step(10);
        chk("t4_level_high", {31'd0, level[2]}, 32'h1);
        chk("t4_pending_first", {31'd0, pending[2]}, 32'h1);
        din[2] = 1'b0;
        expect_pulse(c + 16, 4'b0100);
        step(5);
        clr[2] = 1'b1;
        step(1);
        clr[2] = 1'b0;
        chk("t4_set_wins", {31'd0, pending[2]}, 32'h1);
        chk("t4_level_low", {31'd0, level[2]}, 32'h0);

        // 5. ch3 fall-only mode, clear and irq drop
        mode[7:6] = 2'b10;
        irq_en    = 4'b1000;
        din[3] = 1'b1;
        step(8);
        chk("t5_level_rise", {31'd0, level[3]}, 32'h1);
        chk("t5_no_pending", {31'd0, pending[3]}, 32'h0);
        chk("t5_irq_idle", {31'd0, irq}, 32'h0);
        c = cyc;
        din[3] = 1'b0;
        expect_pulse(c + 6, 4'b1000);
        step(6);
        chk("t5_pending", {31'd0, pending[3]}, 32'h1);
        chk("t5_irq_lag", {31'd0, irq}, 32'h0);
        step(1);
        chk("t5_irq", {31'd0, irq}, 32'h1);
        clr[3] = 1'b1;
        step(1);
        clr[3] = 1'b0;
        chk("t5_clr", {31'd0, pending[3]}, 32'h0);
        chk("t5_irq_hold", {31'd0, irq}, 32'h1);
        step(1);
        chk("t5_irq_drop", {31'd0, irq}, 32'h0);

        // 6. reset in the middle of a debounce count
        din[0] = 1'b0;
        step(10);
        chk("t6_level_low", {31'd0, level[0]}, 32'h0);
        c = cyc;
        din[0] = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        chk("t6_rst_level", {28'd0, level}, 32'h0);
        chk("t6_rst_pulse", {28'd0, pulse}, 32'h0);
        chk("t6_rst_pending", {28'd0, pending}, 32'h0);
        rst = 1'b1;
        expect_pulse(c + 10, 4'b0001);
        step(5);
        chk("t6_level_before", {31'd0, level[0]}, 32'h0);
        step(1);
        chk("t6_level_after", {31'd0, level[0]}, 32'h1);
        chk("t6_pending", {31'd0, pending[0]}, 32'h1);

        step(10);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
